nios_system_nios2_car_controll_oci_dct_ctrl: RTL and testbench

Controls the OCI direct-conditional-trace (DCT) capture buffer. It packs 2-bit trace codes from the CPU into a 30-bit buffer (15 slots) with a 4-bit fill count, then hands each completed or flushed buffer to the trace-memory writer as a 34-bit frame over a valid/ready handshake. It sits between the CPU trace-code source and the OCI trace RAM port. It also exports the live dct_buffer/dct_count to the OCI test bench monitor.

---
 rtl/nios_system_nios2_car_controll_oci_dct_ctrl.sv | 174 +++++++++++++++++
 tb/tb_nios_system_nios2_car_controll_oci_dct_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_car_controll_oci_dct_ctrl.sv
// OCI direct-conditional-trace capture: packs 2-bit trace codes into a NUM_SLOTS-slot
// buffer and hands full or flushed buffers to the trace-memory writer over valid/ready.
module nios_system_nios2_car_controll_oci_dct_ctrl #(
    parameter int unsigned NUM_SLOTS = 15,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trc_on,
    input  logic                     code_valid,
    input  logic [1:0]               code,
    input  logic                     flush,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [2*NUM_SLOTS+3:0]   frame_data,
    output logic [2*NUM_SLOTS-1:0]   dct_buffer,
    output logic [3:0]               dct_count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     busy
);
    localparam int unsigned BW       = 2 * NUM_SLOTS;
    localparam logic [3:0]  FULL_CNT = 4'(NUM_SLOTS);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0]  TO_SAT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH_PEND} state_t;
    state_t state, state_nxt;

    logic [BW-1:0]   buf_nxt, shadow_buf, shadow_buf_nxt;
    logic [3:0]      cnt_nxt, shadow_cnt, shadow_cnt_nxt;
    logic [7:0]      idle_cnt, idle_nxt;
    logic [BW+3:0]   load_word;
    logic            load, accept, drop, go_pend, pend_done, flush_req;
    logic            slot_free, full, code_in;

    assign slot_free = !frame_valid || frame_ready;
    assign full      = (dct_count == FULL_CNT);
    assign code_in   = trc_on && code_valid && (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (trc_on) state_nxt = CAPTURE;
            CAPTURE:    if (go_pend) state_nxt = FLUSH_PEND;
                        else if (!trc_on) state_nxt = IDLE;
            FLUSH_PEND: if (pend_done) state_nxt = trc_on ? CAPTURE : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (dct_count != '0) || frame_valid || (state == FLUSH_PEND);
    end

    always_comb begin
        buf_nxt        = dct_buffer;
        cnt_nxt        = dct_count;
        shadow_buf_nxt = shadow_buf;
        shadow_cnt_nxt = shadow_cnt;
        load_word      = '0;
        load           = 1'b0;
        accept         = 1'b0;
        drop           = 1'b0;
        go_pend        = 1'b0;
        pend_done      = 1'b0;
        flush_req      = 1'b0;
        case (state)
            IDLE: begin
                // leftover from a flush that completed after trace was switched off
                if (dct_count != '0 && slot_free) begin
                    load      = 1'b1;
                    load_word = {dct_count, dct_buffer};
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            CAPTURE: begin
                if (full) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_word = {dct_count, dct_buffer};
                        buf_nxt   = '0;
                        cnt_nxt   = '0;
                        if (code_in) begin
                            accept  = 1'b1;
                            buf_nxt = BW'(code);
                            cnt_nxt = 4'd1;
                        end
                    end else begin
                        drop = code_in;
                    end
                end else begin
                    if (code_in) begin
                        accept  = 1'b1;
                        buf_nxt = {dct_buffer[BW-3:0], code};
                        cnt_nxt = dct_count + 4'd1;
                    end
                    flush_req = flush || !trc_on || (!code_in && idle_cnt >= TO_LAST);
                    if (cnt_nxt == FULL_CNT && slot_free) begin
                        load      = 1'b1;
                        load_word = {cnt_nxt, buf_nxt};
                        buf_nxt   = '0;
                        cnt_nxt   = '0;
                    end else if (flush_req && cnt_nxt != '0) begin
                        if (slot_free) begin
                            load      = 1'b1;
                            load_word = {cnt_nxt, buf_nxt};
                        end else begin
                            shadow_buf_nxt = buf_nxt;
                            shadow_cnt_nxt = cnt_nxt;
                            go_pend        = 1'b1;
                        end
                        buf_nxt = '0;
                        cnt_nxt = '0;
                    end
                end
            end
            FLUSH_PEND: begin
                // live buffer keeps packing while the snapshot waits for the slot
                if (code_in) begin
                    if (!full) begin
                        accept  = 1'b1;
                        buf_nxt = {dct_buffer[BW-3:0], code};
                        cnt_nxt = dct_count + 4'd1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = {shadow_cnt, shadow_buf};
                    pend_done = 1'b1;
                end
            end
            default: ;
        endcase
        if (accept || cnt_nxt == '0) idle_nxt = '0;
        else if (idle_cnt >= TO_SAT) idle_nxt = idle_cnt;
        else                         idle_nxt = idle_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer  <= '0;
            dct_count   <= '0;
            shadow_buf  <= '0;
            shadow_cnt  <= '0;
            idle_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            overflow    <= 1'b0;
        end else begin
            dct_buffer <= buf_nxt;
            dct_count  <= cnt_nxt;
            shadow_buf <= shadow_buf_nxt;
            shadow_cnt <= shadow_cnt_nxt;
            idle_cnt   <= idle_nxt;
            if (load) begin
                frame_valid <= 1'b1;
                frame_data  <= load_word;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (overflow_clr) overflow <= 1'b0;
            else if (drop)    overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nios_system_nios2_car_controll_oci_dct_ctrl.sv
// Directed and randomized checks of the DCT capture controller against a queue-based model.
module tb_nios_system_nios2_car_controll_oci_dct_ctrl;
    localparam int NS = 15;
    localparam int TO = 255;

    logic        clk = 1'b0, reset_n = 1'b0, trc_on = 1'b0, code_valid = 1'b0;
    logic        flush = 1'b0, frame_ready = 1'b0, overflow_clr = 1'b0;
    logic [1:0]  code = '0;
    logic        frame_valid, overflow, busy;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int n_checks = 0;
    int n_errors = 0;

    nios_system_nios2_car_controll_oci_dct_ctrl #(
        .NUM_SLOTS(NS),
        .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .code_valid(code_valid),
        .code(code), .flush(flush), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_data(frame_data), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: live codes and the pending snapshot are kept as code queues
    typedef enum int {M_IDLE, M_CAP, M_PEND} mstate_t;
    logic [1:0]  live[$];
    logic [1:0]  snap[$];
    mstate_t     m_st;
    bit          m_fv, m_ovf;
    logic [33:0] m_fd;
    int          m_idle;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] mk_frame(input logic [1:0] q[$]);
        logic [29:0] b = '0;
        foreach (q[i]) b = b * 30'd4 + 30'(q[i]);
        return {4'(q.size()), b};
    endfunction

    task automatic model_reset();
        live.delete();
        snap.delete();
        m_st = M_IDLE; m_fv = 0; m_ovf = 0; m_fd = '0; m_idle = 0;
    endtask

    task automatic model_step();
        bit sf = !m_fv || frame_ready;
        bit cv = trc_on && code_valid && (m_st != M_IDLE);
        bit ld = 0, acc = 0, drp = 0, freq;
        logic [33:0] w = '0;
        case (m_st)
            M_IDLE: begin
                if (live.size() != 0 && sf) begin w = mk_frame(live); ld = 1; live.delete(); end
                if (trc_on) m_st = M_CAP;
            end
            M_CAP: begin
                if (live.size() == NS) begin
                    if (sf) begin
                        w = mk_frame(live); ld = 1; live.delete();
                        if (cv) begin live.push_back(code); acc = 1; end
                    end else drp = cv;
                end else begin
                    if (cv) begin live.push_back(code); acc = 1; end
                    freq = flush || !trc_on || (!cv && m_idle >= TO - 1);
                    if (live.size() == NS && sf) begin
                        w = mk_frame(live); ld = 1; live.delete();
                    end else if (freq && live.size() != 0) begin
                        if (sf) begin w = mk_frame(live); ld = 1; end
                        else begin snap = live; m_st = M_PEND; end
                        live.delete();
                    end
                end
                if (m_st == M_CAP && !trc_on) m_st = M_IDLE;
            end
            M_PEND: begin
                if (cv) begin
                    if (live.size() < NS) begin live.push_back(code); acc = 1; end
                    else drp = 1;
                end
                if (sf) begin w = mk_frame(snap); ld = 1; m_st = trc_on ? M_CAP : M_IDLE; end
            end
            default: ;
        endcase
        if (ld) begin m_fv = 1; m_fd = w; end
        else if (frame_ready) m_fv = 0;
        m_ovf = overflow_clr ? 1'b0 : (drp ? 1'b1 : m_ovf);
        if (acc || live.size() == 0) m_idle = 0;
        else if (m_idle < TO) m_idle++;
    endtask

    task automatic compare_all();
        logic [33:0] lw = mk_frame(live);
        bit m_busy = (live.size() != 0) || m_fv || (m_st == M_PEND);
        check_eq("frame_valid", 64'(frame_valid), 64'(m_fv));
        check_eq("frame_data",  64'(frame_data),  64'(m_fd));
        check_eq("dct_buffer",  64'(dct_buffer),  64'(lw[29:0]));
        check_eq("dct_count",   64'(dct_count),   64'(live.size()));
        check_eq("overflow",    64'(overflow),    64'(m_ovf));
        check_eq("busy",        64'(busy),        64'(m_busy));
    endtask

    task automatic cyc(input bit tv, input bit cv, input logic [1:0] c,
                       input bit fl, input bit rdy, input bit oc);
        trc_on = tv; code_valid = cv; code = c; flush = fl; frame_ready = rdy; overflow_clr = oc;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tv;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_frame_valid", 64'(frame_valid), 64'd0);
        check_eq("rst_frame_data",  64'(frame_data),  64'd0);
        check_eq("rst_count",       64'(dct_count),   64'd0);
        compare_all();
        reset_n = 1'b1;

        // 15 back-to-back codes fill and transfer on the 15th edge
        cyc(1, 0, 2'b00, 0, 1, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(1, 1, 2'b01, 0, 1, 0);
            if (i == 13) check_eq("t1_count14", 64'(dct_count), 64'd14);
        end
        check_eq("t1_fv",     64'(frame_valid), 64'd1);
        check_eq("t1_frame",  64'(frame_data),  64'({4'd15, 30'h15555555}));
        check_eq("t1_count0", 64'(dct_count),   64'd0);

        // partial frame via flush, then flush with nothing buffered
        cyc(1, 1, 2'b11, 0, 1, 0);
        cyc(1, 1, 2'b10, 0, 1, 0);
        cyc(1, 1, 2'b01, 0, 1, 0);
        cyc(1, 0, 2'b00, 1, 1, 0);
        check_eq("t2_fv",    64'(frame_valid), 64'd1);
        check_eq("t2_frame", 64'(frame_data),  64'({4'd3, 30'h39}));
        cyc(1, 0, 2'b00, 0, 1, 0);
        cyc(1, 0, 2'b00, 1, 1, 0);
        check_eq("t2_empty_flush", 64'(frame_valid), 64'd0);

        // output stalled: second buffer fills, then codes drop
        for (int i = 0; i < 32; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0);
        check_eq("t3_count15", 64'(dct_count),          64'd15);
        check_eq("t3_overflow", 64'(overflow),          64'd1);
        check_eq("t3_held_cnt", 64'(frame_data[33:30]), 64'd15);
        cyc(1, 1, 2'b10, 0, 0, 1);
        check_eq("t3_clr_wins", 64'(overflow), 64'd0);
        repeat (4) cyc(1, 0, 2'b00, 0, 1, 0);

        // idle timeout, with a restart one cycle before expiry
        for (int i = 0; i < 5; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 1, 0);
        repeat (253) cyc(1, 0, 2'b00, 0, 1, 0);
        cyc(1, 1, 2'b11, 0, 1, 0);
        repeat (254) cyc(1, 0, 2'b00, 0, 1, 0);
        check_eq("t4_no_early", 64'(frame_valid), 64'd0);
        cyc(1, 0, 2'b00, 0, 1, 0);
        check_eq("t4_timeout_fv",  64'(frame_valid),       64'd1);
        check_eq("t4_timeout_cnt", 64'(frame_data[33:30]), 64'd6);
        cyc(1, 0, 2'b00, 0, 1, 0);

        // flush while the output slot is held
        cyc(1, 1, 2'b01, 0, 0, 0);
        cyc(1, 1, 2'b10, 0, 0, 0);
        cyc(1, 0, 2'b00, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0);
        cyc(1, 0, 2'b00, 1, 0, 0);
        check_eq("t5_busy_pend", 64'(busy), 64'd1);
        cyc(1, 1, 2'b11, 0, 0, 0);
        cyc(1, 1, 2'b00, 0, 0, 0);
        check_eq("t5_live2", 64'(dct_count), 64'd2);
        cyc(1, 0, 2'b00, 0, 1, 0);
        check_eq("t5_first_cnt", 64'(frame_data[33:30]), 64'd4);
        cyc(1, 0, 2'b00, 1, 0, 0);
        cyc(1, 0, 2'b00, 0, 1, 0);
        check_eq("t5_second_cnt", 64'(frame_data[33:30]), 64'd2);
        cyc(1, 0, 2'b00, 0, 1, 0);
        check_eq("t5_busy_done", 64'(busy), 64'd0);

        // asynchronous reset in the middle of a fill
        for (int i = 0; i < 7; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 1, 0);
        check_eq("t6_count7", 64'(dct_count), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_rst_fv",    64'(frame_valid), 64'd0);
        check_eq("t6_rst_data",  64'(frame_data),  64'd0);
        check_eq("t6_rst_buf",   64'(dct_buffer),  64'd0);
        check_eq("t6_rst_count", 64'(dct_count),   64'd0);
        check_eq("t6_rst_busy",  64'(busy),        64'd0);
        model_reset();
        trc_on = 0; code_valid = 0; flush = 0; frame_ready = 0; overflow_clr = 0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 0, 2'b00, 0, 0, 0);
        cyc(1, 0, 2'b00, 1, 1, 0);
        cyc(1, 0, 2'b00, 1, 1, 0);
        check_eq("t6_no_stale", 64'(frame_valid), 64'd0);

        // randomized traffic
        tv = 1;
        repeat (3000) begin
            if ($urandom_range(99) < 3) tv = !tv;
            cyc(tv, $urandom_range(99) < 70, 2'($urandom_range(3)),
                $urandom_range(99) < 5, $urandom_range(99) < 50, $urandom_range(99) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
